// File: rtl/frac_pkg.sv
// frac_pkg: fixed-point format, helper constants and scan FSM encoding
// shared by the fractal scan controller and its coordinate generator.
package frac_pkg;
    localparam int FRAC_N = 32;
    localparam int FRAC_M = 4;
    localparam int FRAC_F = FRAC_N - FRAC_M;
    localparam logic [FRAC_N-1:0] FRAC_ONE = FRAC_N'(1) << FRAC_F;
    localparam logic [FRAC_N-1:0] FRAC_ESC = FRAC_N'(4) << FRAC_F;
    localparam int S_IDLE  = 0;
    localparam int S_ISSUE = 1;
    localparam int S_WAIT  = 2;
    localparam int S_DONE  = 3;
    typedef enum logic [3:0] {
        IDLE  = 4'(1 << S_IDLE),
        ISSUE = 4'(1 << S_ISSUE),
        WAIT  = 4'(1 << S_WAIT),
        DONE  = 4'(1 << S_DONE)
    } state_e;
endpackage

// File: rtl/frac_coord_gen.sv
// frac_coord_gen: raster col/row/address counters and cx/cy accumulators;
// load starts a frame at (x0,y0), step advances to the next pixel.
module frac_coord_gen import frac_pkg::*; #(
    parameter int N      = FRAC_N,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [N-1:0]      x0_i,
    input  logic [N-1:0]      y0_i,
    input  logic [N-1:0]      dx_i,
    input  logic [N-1:0]      dy_i,
    output logic [N-1:0]      cx_o,
    output logic [N-1:0]      cy_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);
    localparam int CW = $clog2(H_RES + 1);
    localparam int RW = $clog2(V_RES + 1);
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [N-1:0]      x0_q, x0_d, dx_q, dx_d, dy_q, dy_d, cx_q, cx_d, cy_q, cy_d;
    logic              eol;
    assign eol    = col_q == CW'(H_RES - 1);
    assign last_o = eol && row_q == RW'(V_RES - 1);
    assign cx_o   = cx_q;
    assign cy_o   = cy_q;
    assign addr_o = addr_q;
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        x0_d   = x0_q;
        dx_d   = dx_q;
        dy_d   = dy_q;
        cx_d   = cx_q;
        cy_d   = cy_q;
        if (load_i) begin
            x0_d   = x0_i;
            dx_d   = dx_i;
            dy_d   = dy_i;
            cx_d   = x0_i;
            cy_d   = y0_i;
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else if (step_i) begin
            addr_d = addr_q + ADDR_W'(1);
            // line restart reloads x0 so accumulation error never crosses lines
            col_d  = eol ? '0 : col_q + CW'(1);
            cx_d   = eol ? x0_q : cx_q + dx_q;
            row_d  = eol ? row_q + RW'(1) : row_q;
            cy_d   = eol ? cy_q + dy_q : cy_q;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
            x0_q   <= '0;
            dx_q   <= '0;
            dy_q   <= '0;
            cx_q   <= '0;
            cy_q   <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
            x0_q   <= x0_d;
            dx_q   <= dx_d;
            dy_q   <= dy_d;
            cx_q   <= cx_d;
            cy_q   <= cy_d;
        end
    end
endmodule

// File: rtl/frac_scan_ctrl.sv
// frac_scan_ctrl: raster pixel scheduler feeding frac_unit_core and writing
// each found bit to the frame buffer; all outputs registered.
module frac_scan_ctrl import frac_pkg::*; #(
    parameter int N      = FRAC_N,
    parameter int M      = FRAC_M,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              frac_clk,
    input  logic              frac_rst,
    input  logic              scan_start,
    input  logic [N-1:0]      scan_x0,
    input  logic [N-1:0]      scan_y0,
    input  logic [N-1:0]      scan_dx,
    input  logic [N-1:0]      scan_dy,
    input  logic [15:0]       scan_max_iter,
    output logic              scan_busy,
    output logic              scan_done_tick,
    output logic [N-1:0]      frac_cx,
    output logic [N-1:0]      frac_cy,
    output logic [15:0]       frac_max_iter,
    output logic              frac_go,
    input  logic              frac_busy,
    input  logic              frac_done_tick,
    input  logic              frac_found,
    output logic              fb_wr_en,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic              fb_wr_data
);
    state_e            state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d, go_q, go_d;
    logic              wr_en_q, wr_en_d, wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, addr;
    logic [15:0]       max_iter_q, max_iter_d;
    logic              load, step, last;
    frac_coord_gen #(.N(N), .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) u_coord (
        .clk_i  (frac_clk),
        .rst_i  (frac_rst),
        .load_i (load),
        .step_i (step),
        .x0_i   (scan_x0),
        .y0_i   (scan_y0),
        .dx_i   (scan_dx),
        .dy_i   (scan_dy),
        .cx_o   (frac_cx),
        .cy_o   (frac_cy),
        .addr_o (addr),
        .last_o (last)
    );
    assign scan_busy      = busy_q;
    assign scan_done_tick = done_q;
    assign frac_go        = go_q;
    assign frac_max_iter  = max_iter_q;
    assign fb_wr_en       = wr_en_q;
    assign fb_wr_addr     = wr_addr_q;
    assign fb_wr_data     = wr_data_q;
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        go_d       = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        max_iter_d = max_iter_q;
        load       = 1'b0;
        step       = 1'b0;
        case (state_q)
            IDLE: begin
                // a start coinciding with the done tick belongs to the old frame
                if (scan_start && !done_q) begin
                    load       = 1'b1;
                    max_iter_d = scan_max_iter;
                    busy_d     = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (!frac_busy) begin
                    go_d    = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (frac_done_tick) begin
                    step      = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr;
                    wr_data_d = frac_found;
                    state_d   = last ? DONE : ISSUE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge frac_clk) begin
        if (frac_rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            go_q       <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 1'b0;
            max_iter_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            go_q       <= go_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            max_iter_q <= max_iter_d;
        end
    end
endmodule
